i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_sync.sv | 37 +++
 rtl/i2s_rx.sv | 188 ++++++++++++++++++
 tb/tb_i2s_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S receiver.
package i2s_pkg;

  localparam int unsigned DATA_W_DEF = 24;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/i2s_sync.sv
// Multi-stage synchronizer: one edge-detected input plus W plain inputs
// delayed by the same number of stages so they line up with the strobe.
module i2s_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned W           = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         edge_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         rise_c
);

  // One extra stage on the edge path holds the previous synced value.
  logic [SYNC_STAGES:0]          edge_q, edge_d;
  logic [SYNC_STAGES-1:0][W-1:0] data_q, data_d;

  always_comb begin
    edge_d = {edge_q[SYNC_STAGES-1:0], edge_i};
    data_d = {data_q[SYNC_STAGES-2:0], data_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
      data_q <= '0;
    end else begin
      edge_q <= edge_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q[SYNC_STAGES-1];
  assign rise_c = edge_q[SYNC_STAGES-1] & ~edge_q[SYNC_STAGES];

endmodule

// File: rtl/i2s_rx.sv
// I2S stereo receiver: captures DATA_W-bit left/right words from an
// asynchronous codec bus and presents them as a valid/ready pair.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bclk_i,
  input  logic              lrclk_i,
  input  logic              sdata_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_l_o,
  output logic [DATA_W-1:0] data_r_o,
  output logic              overflow_o,
  output logic              frame_err_o
);

  localparam logic [DATA_W-1:0] MSB_BIT = {1'b1, {(DATA_W-1){1'b0}}};

  logic       bclk_rise_c;
  logic [1:0] ws_sd_s;
  logic       lr_s, sd_s;

  i2s_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .W          (2)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .edge_i(bclk_i),
    .data_i({lrclk_i, sdata_i}),
    .data_o(ws_sd_s),
    .rise_c(bclk_rise_c)
  );

  assign lr_s = ws_sd_s[1];
  assign sd_s = ws_sd_s[0];

  state_e            state_q, state_d;
  logic              chan_q, chan_d;
  logic              prev_lr_q, prev_lr_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic              left_ok_q, left_ok_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_l_q, data_l_d;
  logic [DATA_W-1:0] data_r_q, data_r_d;
  logic              ovf_q, ovf_d;
  logic              ferr_q, ferr_d;

  logic              delay_c, word_done_c, pair_c, set_ferr_c;
  logic [DATA_W-1:0] shifted_c, word_c;

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    prev_lr_d   = prev_lr_q;
    mask_d      = mask_q;
    shift_d     = shift_q;
    left_d      = left_q;
    left_ok_d   = left_ok_q;
    valid_d     = valid_q;
    data_l_d    = data_l_q;
    data_r_d    = data_r_q;
    ovf_d       = clr_i ? 1'b0 : ovf_q;
    ferr_d      = clr_i ? 1'b0 : ferr_q;
    word_done_c = 1'b0;
    pair_c      = 1'b0;
    set_ferr_c  = 1'b0;
    word_c      = shift_q;
    delay_c     = bclk_rise_c && (lr_s != prev_lr_q);
    shifted_c   = sd_s ? (shift_q | mask_q) : shift_q;

    if (bclk_rise_c) prev_lr_d = lr_s;

    if (!en_i) begin
      state_d   = SYNC;
      left_ok_d = 1'b0;
    end else if (bclk_rise_c) begin
      unique case (state_q)
        SYNC: begin
          if (delay_c && lr_s == LEFT) begin
            state_d = SHIFT;
            chan_d  = LEFT;
            mask_d  = MSB_BIT;
            shift_d = '0;
          end
        end
        SHIFT: begin
          if (delay_c) begin
            // Short slot: bits not yet captured are already zero.
            word_done_c = 1'b1;
            word_c      = shift_q;
            set_ferr_c  = 1'b1;
            chan_d      = lr_s;
            mask_d      = MSB_BIT;
            shift_d     = '0;
          end else begin
            shift_d = shifted_c;
            mask_d  = mask_q >> 1;
            if (mask_q[0]) begin
              word_done_c = 1'b1;
              word_c      = shifted_c;
              state_d     = HOLD;
            end
          end
        end
        HOLD: begin
          if (delay_c) begin
            state_d = SHIFT;
            chan_d  = lr_s;
            mask_d  = MSB_BIT;
            shift_d = '0;
          end
        end
        default: state_d = SYNC;
      endcase
    end

    if (word_done_c) begin
      if (chan_q == LEFT) begin
        left_d    = word_c;
        left_ok_d = 1'b1;
      end else if (left_ok_q) begin
        pair_c    = 1'b1;
        left_ok_d = 1'b0;
      end
    end

    if (set_ferr_c) ferr_d = 1'b1;

    // Output handshake: a completed pair overwrites only a free or draining slot.
    if (valid_q && ready_i) valid_d = 1'b0;
    if (pair_c) begin
      if (!valid_q || ready_i) begin
        valid_d  = 1'b1;
        data_l_d = left_q;
        data_r_d = word_c;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SYNC;
      chan_q    <= LEFT;
      prev_lr_q <= 1'b0;
      mask_q    <= '0;
      shift_q   <= '0;
      left_q    <= '0;
      left_ok_q <= 1'b0;
      valid_q   <= 1'b0;
      data_l_q  <= '0;
      data_r_q  <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      prev_lr_q <= prev_lr_d;
      mask_q    <= mask_d;
      shift_q   <= shift_d;
      left_q    <= left_d;
      left_ok_q <= left_ok_d;
      valid_q   <= valid_d;
      data_l_q  <= data_l_d;
      data_r_q  <= data_r_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
    end
  end

  assign valid_o     = valid_q;
  assign data_l_o    = data_l_q;
  assign data_r_o    = data_r_q;
  assign overflow_o  = ovf_q;
  assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: bclk = clk/8, 32-bit slots, hand-computed pairs.
module tb_i2s_rx;

  localparam int unsigned DW = 24;

  logic          clk = 1'b0;
  logic          rst_n, bclk, lrclk, sdata, en, clr, ready;
  logic          valid_o, overflow_o, frame_err_o;
  logic [DW-1:0] data_l_o, data_r_o;

  int            errors = 0;
  int            checks = 0;
  int            xfer_cnt = 0;
  logic [DW-1:0] last_l = '0;
  logic [DW-1:0] last_r = '0;

  i2s_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bclk_i     (bclk),
    .lrclk_i    (lrclk),
    .sdata_i    (sdata),
    .en_i       (en),
    .clr_i      (clr),
    .ready_i    (ready),
    .valid_o    (valid_o),
    .data_l_o   (data_l_o),
    .data_r_o   (data_r_o),
    .overflow_o (overflow_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  // Record every completed transfer (valid && ready at the next rising edge).
  always @(negedge clk) begin
    if (valid_o && ready) begin
      xfer_cnt = xfer_cnt + 1;
      last_l   = data_l_o;
      last_r   = data_r_o;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input logic lr, input logic sd);
    lrclk = lr;
    sdata = sd;
    bclk  = 1'b0;
    cyc(4);
    bclk  = 1'b1;
    cyc(4);
  endtask

  // Delay bit, ndata bits MSB-first from a left-justified word, zero fill to total.
  task automatic send_slot(input logic lr, input logic [DW-1:0] word, input int ndata, input int total);
    send_bit(lr, 1'b0);
    for (int i = 0; i < ndata; i++) send_bit(lr, word[int'(DW) - 1 - i]);
    for (int i = ndata + 1; i < total; i++) send_bit(lr, 1'b0);
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    send_slot(1'b0, l, DW, 32);
    send_slot(1'b1, r, DW, 32);
  endtask

  task automatic chk_zero(input string tag);
    chk_eq({tag, "_valid"}, 32'(valid_o), 32'd0);
    chk_eq({tag, "_l"}, 32'(data_l_o), 32'd0);
    chk_eq({tag, "_r"}, 32'(data_r_o), 32'd0);
    chk_eq({tag, "_ovf"}, 32'(overflow_o), 32'd0);
    chk_eq({tag, "_ferr"}, 32'(frame_err_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bclk  = 1'b0;
    lrclk = 1'b1;
    sdata = 1'b0;
    en    = 1'b1;
    clr   = 1'b0;
    ready = 1'b1;
    cyc(3);
    chk_zero("reset");
    rst_n = 1'b1;
    cyc(2);

    // Basic frame
    repeat (4) send_bit(1'b1, 1'b0);
    send_frame(24'h123456, 24'hABCDEF);
    chk_eq("basic_cnt", 32'(xfer_cnt), 32'd1);
    chk_eq("basic_l", 32'(last_l), 32'h123456);
    chk_eq("basic_r", 32'(last_r), 32'hABCDEF);
    chk_eq("basic_valid_low", 32'(valid_o), 32'd0);
    chk_eq("basic_ovf", 32'(overflow_o), 32'd0);
    chk_eq("basic_ferr", 32'(frame_err_o), 32'd0);

    // Start in the middle of a right slot
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    repeat (12) send_bit(1'b1, 1'b1);
    send_frame(24'h111111, 24'h222222);
    chk_eq("mid_cnt", 32'(xfer_cnt), 32'd2);
    chk_eq("mid_l", 32'(last_l), 32'h111111);
    chk_eq("mid_r", 32'(last_r), 32'h222222);

    // Backpressure and overflow
    ready = 1'b0;
    send_frame(24'd1, 24'd2);
    send_frame(24'd3, 24'd4);
    send_frame(24'd5, 24'd6);
    chk_eq("ovf_valid", 32'(valid_o), 32'd1);
    chk_eq("ovf_hold_l", 32'(data_l_o), 32'd1);
    chk_eq("ovf_hold_r", 32'(data_r_o), 32'd2);
    chk_eq("ovf_flag", 32'(overflow_o), 32'd1);
    chk_eq("ovf_cnt", 32'(xfer_cnt), 32'd2);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(1);
    chk_eq("ovf_clr", 32'(overflow_o), 32'd0);
    chk_eq("ovf_valid_kept", 32'(valid_o), 32'd1);
    ready = 1'b1;
    cyc(2);
    chk_eq("drain_cnt", 32'(xfer_cnt), 32'd3);
    chk_eq("drain_l", 32'(last_l), 32'd1);
    chk_eq("drain_r", 32'(last_r), 32'd2);
    chk_eq("drain_valid_low", 32'(valid_o), 32'd0);

    // Short right slot of 16 bits
    send_slot(1'b0, 24'h00AAAA, DW, 32);
    send_slot(1'b1, 24'h800100, 16, 17);
    send_slot(1'b0, 24'h000003, DW, 32);
    chk_eq("short_cnt", 32'(xfer_cnt), 32'd4);
    chk_eq("short_l", 32'(last_l), 32'h00AAAA);
    chk_eq("short_r", 32'(last_r), 32'h800100);
    chk_eq("short_ferr", 32'(frame_err_o), 32'd1);
    send_slot(1'b1, 24'h000004, DW, 32);
    chk_eq("after_short_cnt", 32'(xfer_cnt), 32'd5);
    chk_eq("after_short_l", 32'(last_l), 32'h000003);
    chk_eq("after_short_r", 32'(last_r), 32'h000004);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(1);
    chk_eq("ferr_clr", 32'(frame_err_o), 32'd0);

    // Reset after 10 left bits
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'(i & 1));
    rst_n = 1'b0;
    cyc(2);
    chk_zero("midrst");
    rst_n = 1'b1;
    cyc(2);
    send_slot(1'b1, 24'h5A5A5A, DW, 32);
    send_frame(24'h000001, 24'hFFFFFF);
    chk_eq("postrst_cnt", 32'(xfer_cnt), 32'd6);
    chk_eq("postrst_l", 32'(last_l), 32'h000001);
    chk_eq("postrst_r", 32'(last_r), 32'hFFFFFF);

    // Disable for two frames, re-enable inside a left slot
    en = 1'b0;
    send_frame(24'd7, 24'd8);
    send_frame(24'd9, 24'd10);
    chk_eq("dis_cnt", 32'(xfer_cnt), 32'd6);
    chk_eq("dis_valid", 32'(valid_o), 32'd0);
    send_bit(1'b0, 1'b0);
    repeat (8) send_bit(1'b0, 1'b1);
    en = 1'b1;
    repeat (23) send_bit(1'b0, 1'b1);
    send_slot(1'b1, 24'h00000D, DW, 32);
    chk_eq("reen_partial_cnt", 32'(xfer_cnt), 32'd6);
    send_frame(24'h00000B, 24'h00000C);
    chk_eq("reen_cnt", 32'(xfer_cnt), 32'd7);
    chk_eq("reen_l", 32'(last_l), 32'h00000B);
    chk_eq("reen_r", 32'(last_r), 32'h00000C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
